// File: rtl/rs232c_rx.sv
// RS-232C (UART) receiver: 8 data bits, no parity, 1 stop bit, LSB first,
// idle-high line. The asynchronous rx pin is synchronized, then each bit is
// sampled at its midpoint by counting system clocks from the start edge.
// A good byte is presented with a one-cycle valid strobe; a low stop bit
// produces a one-cycle frame_err strobe instead and leaves data untouched.
module rs232c_rx #(
  parameter int CLOCK    = 50_000_000,
  parameter int BAUDRATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DATA_W      = 8;
  localparam int BIT_CYCLES  = CLOCK / BAUDRATE;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  // Counter must hold BIT_CYCLES-1 so it never wraps inside a bit.
  localparam int CNT_W       = (BIT_CYCLES >= 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W       = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic              rx_p0;
  logic              rx_s;
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shreg;

  // Two-flop synchronizer for the asynchronous line; presets to idle (high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

  // Frame FSM: detect start edge, sample each bit at mid-bit, check stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            // A line already high again at mid-start-bit was only a glitch.
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_W-1:1]};
            if (idx == IDX_LAST) state <= STOP;
            else                 idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            // Returning to IDLE at the stop midpoint lets back-to-back frames
            // re-arm in time for the next start edge.
            state <= IDLE;
            if (rx_s) begin
              data  <= shreg;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rs232c_rx.sv
// Testbench for rs232c_rx. Instance 0 runs at 16 clocks per bit for the
// functional cases; instances 1..3 use the default 50 MHz / 9600 baud
// configuration and receive a frame at nominal, fast and slow bit times.
module tb_rs232c_rx;

  typedef struct packed {
    logic       err;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst0;
  logic       rst1;
  logic [3:0] rx_v;
  logic [3:0] valid_v;
  logic [3:0] ferr_v;
  logic [3:0] busy_v;
  logic [7:0] data_v [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_v = 0;
  int prev_v = 0;
  ev_t exp_q [4][$];
  ev_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  rs232c_rx #(.CLOCK(16), .BAUDRATE(1)) u_small (
    .clk(clk), .rst(rst0), .rx(rx_v[0]), .data(data_v[0]),
    .valid(valid_v[0]), .frame_err(ferr_v[0]), .busy(busy_v[0]));

  rs232c_rx u_nom (
    .clk(clk), .rst(rst1), .rx(rx_v[1]), .data(data_v[1]),
    .valid(valid_v[1]), .frame_err(ferr_v[1]), .busy(busy_v[1]));

  rs232c_rx u_fast (
    .clk(clk), .rst(rst1), .rx(rx_v[2]), .data(data_v[2]),
    .valid(valid_v[2]), .frame_err(ferr_v[2]), .busy(busy_v[2]));

  rs232c_rx u_slow (
    .clk(clk), .rst(rst1), .rx(rx_v[3]), .data(data_v[3]),
    .valid(valid_v[3]), .frame_err(ferr_v[3]), .busy(busy_v[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int i, input logic err, input logic [7:0] d);
    ev_t e;
    e.err = err;
    e.d   = d;
    exp_q[i].push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame on line i, bc clocks per bit; rx changes on negedges.
  task automatic send_frame(input int i, input logic [7:0] b, input logic stop, input int bc);
    rx_v[i] = 1'b0;
    idle(bc);
    for (int j = 0; j < 8; j++) begin
      rx_v[i] = b[j];
      idle(bc);
    end
    rx_v[i] = stop;
    idle(bc);
    rx_v[i] = 1'b1;
  endtask

  // Scoreboard monitor: every valid/frame_err pulse pops one expected event.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (valid_v[i] || ferr_v[i]) begin
        check($sformatf("exclusive_dut%0d", i), {31'd0, valid_v[i] & ferr_v[i]}, 32'd0);
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse dut%0d actual valid=%0b frame_err=%0b data=%02h required no pulse",
                   i, valid_v[i], ferr_v[i], data_v[i]);
        end else begin
          mon_e = exp_q[i].pop_front();
          check($sformatf("kind_dut%0d", i), {31'd0, ferr_v[i]}, {31'd0, mon_e.err});
          check($sformatf("data_dut%0d", i), {24'd0, data_v[i]}, {24'd0, mon_e.d});
        end
        if (i == 0 && valid_v[0]) begin
          prev_v = last_v;
          last_v = cyc;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b0;
    rst1 = 1'b0;
    rx_v = 4'hF;
    #1;
    rst0 = 1'b1;
    rst1 = 1'b1;
    idle(3);
    check("rst_data",  {24'd0, data_v[0]}, 32'd0);
    check("rst_valid", {31'd0, valid_v[0]}, 32'd0);
    check("rst_ferr",  {31'd0, ferr_v[0]}, 32'd0);
    check("rst_busy",  {31'd0, busy_v[0]}, 32'd0);
    check("rst_data_def", {24'd0, data_v[1]}, 32'd0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    idle(2);

    fork
      // Default configuration: nominal, +2% and -2% bit times.
      begin
        fork
          begin expect_ev(1, 1'b0, 8'h41); send_frame(1, 8'h41, 1'b1, 5208); end
          begin expect_ev(2, 1'b0, 8'h41); send_frame(2, 8'h41, 1'b1, 5104); end
          begin expect_ev(3, 1'b0, 8'h41); send_frame(3, 8'h41, 1'b1, 5312); end
        join
      end
      // 16-clocks-per-bit functional sequence.
      begin
        expect_ev(0, 1'b0, 8'h55);
        send_frame(0, 8'h55, 1'b1, 16);
        idle(4);
        check("single_busy", {31'd0, busy_v[0]}, 32'd0);
        check("single_data", {24'd0, data_v[0]}, 32'h55);

        expect_ev(0, 1'b0, 8'hA5);
        expect_ev(0, 1'b0, 8'h3C);
        send_frame(0, 8'hA5, 1'b1, 16);
        send_frame(0, 8'h3C, 1'b1, 16);
        idle(4);
        check("b2b_gap", last_v - prev_v, 32'd160);

        rx_v[0] = 1'b0;
        idle(4);
        check("glitch_busy_hi", {31'd0, busy_v[0]}, 32'd1);
        rx_v[0] = 1'b1;
        idle(20);
        check("glitch_busy_lo", {31'd0, busy_v[0]}, 32'd0);
        expect_ev(0, 1'b0, 8'h81);
        send_frame(0, 8'h81, 1'b1, 16);
        idle(4);

        expect_ev(0, 1'b1, 8'h81);
        send_frame(0, 8'hFF, 1'b0, 16);
        idle(20);
        check("ferr_busy", {31'd0, busy_v[0]}, 32'd0);
        check("ferr_data_held", {24'd0, data_v[0]}, 32'h81);

        // 0x5A aborted by reset halfway through data bit 4.
        rx_v[0] = 1'b0;
        idle(16);
        rx_v[0] = 1'b0; idle(16);
        rx_v[0] = 1'b1; idle(16);
        rx_v[0] = 1'b0; idle(16);
        rx_v[0] = 1'b1; idle(16);
        rx_v[0] = 1'b1; idle(8);
        check("abort_busy_before", {31'd0, busy_v[0]}, 32'd1);
        rst0 = 1'b1;
        #1;
        check("abort_rst_data",  {24'd0, data_v[0]}, 32'd0);
        check("abort_rst_valid", {31'd0, valid_v[0]}, 32'd0);
        check("abort_rst_ferr",  {31'd0, ferr_v[0]}, 32'd0);
        check("abort_rst_busy",  {31'd0, busy_v[0]}, 32'd0);
        rx_v[0] = 1'b1;
        idle(2);
        rst0 = 1'b0;
        idle(40);
        check("abort_after_busy", {31'd0, busy_v[0]}, 32'd0);
        expect_ev(0, 1'b0, 8'h12);
        send_frame(0, 8'h12, 1'b1, 16);
        idle(4);
        check("abort_new_data", {24'd0, data_v[0]}, 32'h12);
      end
    join

    idle(20);
    for (int i = 0; i < 4; i++)
      check($sformatf("pending_dut%0d", i), exp_q[i].size(), 32'd0);
    check("def_fast_busy", {31'd0, busy_v[2]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
